ram_param_clr: RTL and testbench
================================

RAM_PARAM_CLR -- requirements
Module: ram_param_clr

Interface
REQ-001 DATA_WIDTH, 8, word width in bits; SHALL be a multiple of 8.
REQ-002 ADDR_WIDTH, 8, address width; depth SHALL be DEPTH = 2**ADDR_WIDTH words.
REQ-003 RDW_MODE, 0, same-address read-during-write result; 0 = old data (read-first), 1 = new data (write-first).
REQ-004 CLEAR_VALUE, 0, DATA_WIDTH-bit value written to every word during a clear sweep.
REQ-005 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 rst_n  input  1  reset; asynchronous, active-low.
REQ-007 address  input  ADDR_WIDTH  word address shared by read and write.
REQ-008 write_en  input  1  write request, sampled at the rising edge.
REQ-009 write_data  input  DATA_WIDTH  write word.
REQ-010 byte_en  input  DATA_WIDTH/8  per-byte write lane enable; bit i covers bits [8i+7:8i].
REQ-011 read_en  input  1  read request, sampled at the rising edge.
REQ-012 clear_req  input  1  single-cycle request to re-clear the whole array.
REQ-013 read_data  output  DATA_WIDTH  registered read word.
REQ-014 read_valid  output  1  high for exactly one cycle per accepted read.
REQ-015 busy  output  1  high while a clear sweep runs; requests are not accepted.

Function
REQ-016 Two states: CLEAR and IDLE.
REQ-017 CLEAR: an ADDR_WIDTH-bit sweep counter starting at 0 writes CLEAR_VALUE to one word per cycle and increments by 1.
REQ-018 CLEAR -> IDLE after the cycle that writes word DEPTH-1; a sweep SHALL last exactly DEPTH cycles, and busy SHALL fall on the edge after the last clear write.
REQ-019 IDLE -> CLEAR when clear_req=1 at a rising edge; the counter restarts at 0 and busy rises on that edge.
REQ-020 clear_req SHALL take priority over write_en and read_en in the same cycle; both are dropped and read_valid stays 0.
REQ-021 While busy=1: write_en, read_en and clear_req SHALL be ignored, the array holds only clear writes, and read_valid SHALL be 0.
REQ-022 Write (IDLE, write_en=1): each lane with byte_en[i]=1 takes write_data's byte i; lanes with 0 keep old contents; byte_en all-zero is a no-op.
REQ-023 Read (IDLE, read_en=1 at edge N): read_data SHALL hold mem[address] and read_valid=1 after edge N (latency 1), with read_valid back at 0 after edge N+1 unless read again.
REQ-024 read_data SHALL hold its last value whenever no read is accepted, including through a clear sweep.
REQ-025 Same-edge read and write to the same address: RDW_MODE=0 returns pre-write word; RDW_MODE=1 returns post-write merged word (byte_en applied).
REQ-026 Same-edge read and write to different addresses SHALL both complete.
REQ-027 Sweep counter SHALL NOT wrap: no clear writes occur after word DEPTH-1.

Reset
REQ-028 rst_n=0 SHALL immediately force read_data=0, read_valid=0, busy=1, state CLEAR, counter=0, regardless of clock.
REQ-029 On rst_n release, a full DEPTH-cycle sweep SHALL run before any request is accepted.
REQ-030 rst_n asserted mid-sweep SHALL abort the sweep; on release, the sweep restarts at word 0.

Verification (DATA_WIDTH=16, ADDR_WIDTH=4, CLEAR_VALUE=0 unless stated)
REQ-031 Release rst_n -> busy=1 for exactly 16 cycles then 0; read addr 5 -> read_data=16'h0000 with read_valid=1 one cycle later.
REQ-032 Write addr 2 = 16'hFBFB with byte_en=2'b11, then read addr 2 -> 16'hFBFB, read_valid for one cycle; write with byte_en=2'b00 to addr 2 -> still 16'hFBFB.
REQ-033 Write addr 3 = 16'h1234 with byte_en=2'b11, then 16'hABCD with byte_en=2'b01, read addr 3 -> 16'h12CD.
REQ-034 Addr 2 holds 16'hFBFB; same-edge write 16'h5555 plus read addr 2 -> RDW_MODE=0: 16'hFBFB, then re-read 16'h5555; RDW_MODE=1: 16'h5555.
REQ-035 After writes, pulse clear_req together with write addr 4 = 16'h7777 -> busy=1 for 16 cycles; writes and reads during busy ignored (read_valid=0); afterwards addr 2 and addr 4 read 16'h0000.
REQ-036 Assert rst_n=0 when the sweep counter reaches 7 -> outputs reset asynchronously; after release, busy=1 for a full 16 cycles.

Source files
------------

// File: rtl/ram_param_clr.sv
// Single-port byte-writable RAM with a hardware clear sweep.
// The sweep runs after reset or on request; user traffic is accepted only once it finishes.
module ram_param_clr #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    RDW_MODE    = 0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic                    write_en,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic [DATA_WIDTH/8-1:0] byte_en,
    input  logic                    read_en,
    input  logic                    clear_req,
    output logic [DATA_WIDTH-1:0]   read_data,
    output logic                    read_valid,
    output logic                    busy
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                    rd_valid_q, rd_valid_d;

    logic                    user_we;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_word;
    logic [NB-1:0]           lane_we;
    logic [DATA_WIDTH-1:0]   old_word;
    logic [DATA_WIDTH-1:0]   merged_word;

    // A clear request in the same cycle suppresses any user write.
    assign user_we = (state_q == ST_IDLE) && !clear_req && write_en;
    assign wr_addr = (state_q == ST_CLEAR) ? cnt_q : address;
    assign wr_word = (state_q == ST_CLEAR) ? CLEAR_VALUE : write_data;

    // One narrow array per byte lane so each lane has its own write enable.
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        logic [7:0] mem_lane [DEPTH];

        assign lane_we[gi] = (state_q == ST_CLEAR) || (user_we && byte_en[gi]);

        always_ff @(posedge clk) begin
            if (lane_we[gi]) begin
                mem_lane[wr_addr] <= wr_word[gi*8 +: 8];
            end
        end

        assign old_word[gi*8 +: 8]    = mem_lane[address];
        assign merged_word[gi*8 +: 8] = (user_we && byte_en[gi]) ? write_data[gi*8 +: 8]
                                                                  : mem_lane[address];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        case (state_q)
            ST_CLEAR: begin
                if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            ST_IDLE: begin
                if (clear_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end else if (read_en) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = (RDW_MODE != 0) ? merged_word : old_word;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_CLEAR;
            cnt_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign read_data  = rd_data_q;
    assign read_valid = rd_valid_q;
    assign busy       = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_ram_param_clr.sv
// Scoreboard bench for ram_param_clr: read-first and write-first instances share stimulus.
module tb_ram_param_clr;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  address = '0;
    logic        write_en = 1'b0;
    logic [15:0] write_data = '0;
    logic [1:0]  byte_en = '0;
    logic        read_en = 1'b0;
    logic        clear_req = 1'b0;
    logic [15:0] rd0, rd1;
    logic        rv0, rv1, busy0, busy1;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [15:0] q0[$];
    logic [15:0] q1[$];

    always #5 clk = ~clk;

    ram_param_clr #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .RDW_MODE(0), .CLEAR_VALUE(16'h0000)) dut0 (
        .clk(clk), .rst_n(rst_n), .address(address), .write_en(write_en),
        .write_data(write_data), .byte_en(byte_en), .read_en(read_en), .clear_req(clear_req),
        .read_data(rd0), .read_valid(rv0), .busy(busy0));

    ram_param_clr #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .RDW_MODE(1), .CLEAR_VALUE(16'h0000)) dut1 (
        .clk(clk), .rst_n(rst_n), .address(address), .write_en(write_en),
        .write_data(write_data), .byte_en(byte_en), .read_en(read_en), .clear_req(clear_req),
        .read_data(rd1), .read_valid(rv1), .busy(busy1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
            $display("check %s: got %0h expected %0h ok", name, act, exp);
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every read_valid pops the matching expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rv0) begin
                if (q0.size() == 0) chk("dut0_unexpected_valid", 32'(rv0), 32'd0);
                else chk("dut0_read", 32'(rd0), 32'(q0.pop_front()));
            end
            if (rv1) begin
                if (q1.size() == 0) chk("dut1_unexpected_valid", 32'(rv1), 32'd0);
                else chk("dut1_read", 32'(rd1), 32'(q1.pop_front()));
            end
        end
    end

    task automatic op(input logic we, input logic re, input logic clr, input logic [3:0] a,
                      input logic [15:0] wd, input logic [1:0] be, input logic push,
                      input logic [15:0] e0, input logic [15:0] e1);
        write_en = we; read_en = re; clear_req = clr;
        address = a; write_data = wd; byte_en = be;
        if (push) begin
            q0.push_back(e0);
            q1.push_back(e1);
        end
        @(posedge clk); #1;
        write_en = 1'b0; read_en = 1'b0; clear_req = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
        op(1'b1, 1'b0, 1'b0, a, d, be, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic rd(input logic [3:0] a, input logic [15:0] e0, input logic [15:0] e1);
        op(1'b0, 1'b1, 1'b0, a, 16'h0, 2'b00, 1'b1, e0, e1);
    endtask

    // Counts negedges with busy high; ends on a negedge with busy low.
    task automatic measure_busy(input string name);
        int n0 = 0;
        int n1 = 0;
        logic bad_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy0) n0++;
            if (busy1) n1++;
            if ((busy0 || busy1) && (rv0 || rv1)) bad_valid = 1'b1;
            if (!busy0 && !busy1) break;
        end
        chk({name, "_dut0"}, 32'(n0), 32'd16);
        chk({name, "_dut1"}, 32'(n1), 32'd16);
        chk({name, "_no_valid_while_busy"}, 32'(bad_valid), 32'd0);
    endtask

    initial begin
        #2;
        chk("reset_busy", 32'({busy0, busy1}), 32'h3);
        chk("reset_valid", 32'({rv0, rv1}), 32'h0);
        chk("reset_data", {rd0, rd1}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        measure_busy("init_sweep");
        @(posedge clk); #1;

        rd(4'd5, 16'h0000, 16'h0000);
        wr(4'd2, 16'hFBFB, 2'b11);
        rd(4'd2, 16'hFBFB, 16'hFBFB);
        wr(4'd2, 16'h0000, 2'b00);
        rd(4'd2, 16'hFBFB, 16'hFBFB);
        wr(4'd3, 16'h1234, 2'b11);
        wr(4'd3, 16'hABCD, 2'b01);
        rd(4'd3, 16'h12CD, 16'h12CD);
        op(1'b1, 1'b1, 1'b0, 4'd2, 16'h5555, 2'b11, 1'b1, 16'hFBFB, 16'h5555);
        rd(4'd2, 16'h5555, 16'h5555);
        @(posedge clk); @(posedge clk); #1;
        chk("hold_valid_low", 32'({rv0, rv1}), 32'h0);
        chk("hold_data", {rd0, rd1}, 32'h55555555);

        // Clear with a competing write; then hammer requests throughout the sweep.
        wr(4'd4, 16'h4444, 2'b11);
        op(1'b1, 1'b1, 1'b1, 4'd4, 16'h7777, 2'b11, 1'b0, 16'h0, 16'h0);
        write_en = 1'b1; read_en = 1'b1; clear_req = 1'b1;
        address = 4'd2; write_data = 16'h9999; byte_en = 2'b11;
        measure_busy("clear_sweep");
        write_en = 1'b0; read_en = 1'b0; clear_req = 1'b0;
        chk("sweep_hold_data", {rd0, rd1}, 32'h55555555);
        @(posedge clk); #1;
        rd(4'd2, 16'h0000, 16'h0000);
        rd(4'd4, 16'h0000, 16'h0000);
        rd(4'd3, 16'h0000, 16'h0000);

        // Abort a sweep with reset when its counter is at 7.
        wr(4'd6, 16'hBEEF, 2'b11);
        rd(4'd6, 16'hBEEF, 16'hBEEF);
        op(1'b0, 1'b0, 1'b1, 4'd0, 16'h0, 2'b00, 1'b0, 16'h0, 16'h0);
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_data", {rd0, rd1}, 32'h0);
        chk("async_rst_valid", 32'({rv0, rv1}), 32'h0);
        chk("async_rst_busy", 32'({busy0, busy1}), 32'h3);
        @(posedge clk); #1;
        rst_n = 1'b1;
        measure_busy("restart_sweep");
        @(posedge clk); #1;
        rd(4'd6, 16'h0000, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
